montgomery_modexp_ctrl: RTL and testbench

- Sequential modular-exponentiation controller: computes result = base^exponent mod modulant.
- Schedules a sequence of Montgomery products on one internal bit-serial Montgomery product unit (radix-2, one reduction step per cycle), using left-to-right square-and-multiply.
- Sits between the processor-side register interface and the Montgomery datapath.
- Software supplies r2_mod = R² mod modulant, with R = 2^bit_length.

---
 rtl/montgomery_modexp_ctrl.sv | 167 ++++++++++++++++
 tb/tb_montgomery_modexp_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_modexp_ctrl.sv
// Modular exponentiation controller: left-to-right square-and-multiply scheduled
// onto a single radix-2 bit-serial Montgomery product unit (one reduction step per cycle).
module montgomery_modexp_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] base,
    input  logic [DATA_WIDTH-1:0] exponent,
    input  logic [DATA_WIDTH-1:0] modulant,
    input  logic [DATA_WIDTH-1:0] bit_length,
    input  logic [DATA_WIDTH-1:0] r2_mod,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int AW = DATA_WIDTH + 2;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [DATA_WIDTH-1:0] DW_MAX = DATA_WIDTH'(DATA_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_CORR, S_DONE} state_e;
    typedef enum logic [2:0] {OP_XB, OP_ONE, OP_SQR, OP_MUL, OP_FIN} op_e;

    typedef struct packed {
        state_e                state;
        op_e                   op;
        logic                  busy;
        logic                  done;
        logic [DATA_WIDTH-1:0] base;
        logic [DATA_WIDTH-1:0] expo;
        logic [DATA_WIDTH-1:0] n;
        logic [DATA_WIDTH-1:0] r2;
        logic [DATA_WIDTH-1:0] xb;
        logic [DATA_WIDTH-1:0] acc;
        logic [DATA_WIDTH-1:0] x;
        logic [DATA_WIDTH-1:0] y;
        logic [DATA_WIDTH-1:0] result;
        logic [AW-1:0]         a;
        logic [CW-1:0]         k;
        logic [CW-1:0]         cnt;
        logic [IW-1:0]         bidx;
    } regs_t;

    regs_t r_q, r_d;

    logic [CW-1:0]         k_cap;
    logic [DATA_WIDTH-1:0] x_sel, y_sel, mp_out;
    logic [AW-1:0]         a_add, a_odd, a_step;
    logic                  a_ge_n;

    always_comb begin
        if (bit_length == '0) begin
            k_cap = CW'(1);
        end else if (bit_length > DW_MAX) begin
            k_cap = CW'(DATA_WIDTH);
        end else begin
            k_cap = bit_length[CW-1:0];
        end
    end

    // One reduction step: a <- (a + x[i]*y [+ n]) / 2; the width keeps a < 2^(DATA_WIDTH+1).
    assign a_add  = r_q.a + (r_q.x[0] ? {2'b00, r_q.y} : AW'(0));
    assign a_odd  = a_add[0] ? (a_add + {2'b00, r_q.n}) : a_add;
    assign a_step = a_odd >> 1;

    // a < 2n here, so after one conditional subtract the value fits in DATA_WIDTH bits.
    assign a_ge_n = (r_q.a >= {2'b00, r_q.n});
    assign mp_out = a_ge_n ? (r_q.a[DATA_WIDTH-1:0] - r_q.n) : r_q.a[DATA_WIDTH-1:0];

    always_comb begin
        x_sel = r_q.acc;
        y_sel = DATA_WIDTH'(1);
        unique case (r_q.op)
            OP_XB:   begin x_sel = r_q.base;        y_sel = r_q.r2;  end
            OP_ONE:  begin x_sel = DATA_WIDTH'(1);  y_sel = r_q.r2;  end
            OP_SQR:  begin x_sel = r_q.acc;         y_sel = r_q.acc; end
            OP_MUL:  begin x_sel = r_q.acc;         y_sel = r_q.xb;  end
            default: begin x_sel = r_q.acc;         y_sel = DATA_WIDTH'(1); end
        endcase
    end

    always_comb begin
        // NOTE: r_d starts as a copy of r_q so every path assigns it; no latch is inferred.
        r_d = r_q;
        unique case (r_q.state)
            S_IDLE: begin
                if (start) begin
                    r_d.base  = base;
                    r_d.expo  = exponent;
                    r_d.n     = modulant;
                    r_d.r2    = r2_mod;
                    r_d.k     = k_cap;
                    r_d.op    = OP_XB;
                    r_d.bidx  = IW'(DATA_WIDTH - 1);
                    r_d.busy  = 1'b1;
                    r_d.state = S_LOAD;
                end
            end
            S_LOAD: begin
                r_d.x     = x_sel;
                r_d.y     = y_sel;
                r_d.a     = '0;
                r_d.cnt   = '0;
                r_d.state = S_ITER;
            end
            S_ITER: begin
                r_d.a   = a_step;
                r_d.x   = r_q.x >> 1;
                r_d.cnt = r_q.cnt + CW'(1);
                if (r_q.cnt == r_q.k - CW'(1)) begin
                    r_d.state = S_CORR;
                end
            end
            S_CORR: begin
                r_d.state = S_LOAD;
                unique case (r_q.op)
                    OP_XB: begin
                        r_d.xb = mp_out;
                        r_d.op = OP_ONE;
                    end
                    OP_ONE: begin
                        r_d.acc = mp_out;
                        r_d.op  = OP_SQR;
                    end
                    OP_SQR, OP_MUL: begin
                        r_d.acc = mp_out;
                        if (r_q.op == OP_SQR && r_q.expo[r_q.bidx]) begin
                            r_d.op = OP_MUL;
                        end else if (r_q.bidx == '0) begin
                            r_d.op = OP_FIN;
                        end else begin
                            r_d.op   = OP_SQR;
                            r_d.bidx = r_q.bidx - IW'(1);
                        end
                    end
                    default: begin
                        r_d.result = mp_out;
                        r_d.done   = 1'b1;
                        r_d.busy   = 1'b0;
                        r_d.state  = S_DONE;
                    end
                endcase
            end
            default: begin
                r_d.done  = 1'b0;
                r_d.state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign busy   = r_q.busy;
    assign done   = r_q.done;
    assign result = r_q.result;

endmodule

// File: tb/tb_montgomery_modexp_ctrl.sv
// Scoreboard bench for montgomery_modexp_ctrl: the driver queues expected result and
// latency per start, a monitor compares whenever done pulses.
module tb_montgomery_modexp_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] base, exponent, modulant, bit_length, r2_mod;
    logic          busy, done;
    logic [DW-1:0] result;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int busy_cnt = 0;

    typedef struct {
        logic [DW-1:0] res;
        int            lat;
        int            t0;
        string         name;
    } exp_t;

    exp_t sb_q[$];

    montgomery_modexp_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base       (base),
        .exponent   (exponent),
        .modulant   (modulant),
        .bit_length (bit_length),
        .r2_mod     (r2_mod),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int exp_latency(input logic [DW-1:0] kb, input logic [DW-1:0] e);
        int kc;
        kc = (kb == 0) ? 1 : ((kb > DW) ? DW : int'(kb));
        return (kc + 2) * (3 + DW + $countones(e));
    endfunction

    function automatic logic [DW-1:0] powmod(input int b, input int e, input int n);
        int r;
        r = 1 % n;
        for (int i = 0; i < e; i++) r = (r * b) % n;
        return DW'(r);
    endfunction

    // Monitor: compares every done pulse against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check({e.name, "_result"}, result, e.res);
                        check({e.name, "_latency"}, cyc - e.t0, e.lat);
                        check({e.name, "_busy_cycles"}, busy_cnt, e.lat);
                        check({e.name, "_busy_low_in_done"}, busy, 0);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    // Called just after a negedge; returns at the negedge following the capture edge.
    task automatic issue(input string name, input logic [DW-1:0] b, input logic [DW-1:0] e,
                         input logic [DW-1:0] n, input logic [DW-1:0] kb,
                         input logic [DW-1:0] r2, input logic [DW-1:0] res, input int lat);
        exp_t item;
        base       = b;
        exponent   = e;
        modulant   = n;
        bit_length = kb;
        r2_mod     = r2;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        item.res  = res;
        item.lat  = lat;
        item.t0   = cyc;
        item.name = name;
        sb_q.push_back(item);
    endtask

    task automatic wait_done(input string name, input int bound);
        int waited = 0;
        while (!done && waited < bound) begin
            @(negedge clk);
            waited++;
        end
        if (!done) begin
            check({name, "_timeout"}, 0, 1);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_seen;
        logic [DW-1:0] rk, rn, rb, re, rr;

        reset = 1'b1; start = 1'b0;
        base = '0; exponent = '0; modulant = '0; bit_length = '0; r2_mod = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors with hand-computed results.
        issue("n13_b7_e5", 8'd7, 8'd5, 8'd13, 8'd4, 8'd9, 8'd11, 78);
        wait_done("n13_b7_e5", 200);
        issue("n13_b7_e0", 8'd7, 8'd0, 8'd13, 8'd4, 8'd9, 8'd1, 66);
        wait_done("n13_b7_e0", 200);
        issue("n13_b0_e3", 8'd0, 8'd3, 8'd13, 8'd4, 8'd9, 8'd0, 78);
        wait_done("n13_b0_e3", 200);
        issue("n251_b2_e255", 8'd2, 8'd255, 8'd251, 8'd8, 8'd25, 8'd32, 190);
        wait_done("n251_b2_e255", 300);
        issue("n251_k12_clamp", 8'd2, 8'd255, 8'd251, 8'd12, 8'd25, 8'd32, 190);
        wait_done("n251_k12_clamp", 300);

        // Start re-pulsed and inputs changed mid-run: no effect, no second run.
        issue("midrun_start", 8'd7, 8'd5, 8'd13, 8'd4, 8'd9, 8'd11, 78);
        repeat (9) @(negedge clk);
        start = 1'b1; base = 8'd3; exponent = 8'hFF; modulant = 8'd7;
        @(negedge clk);
        start = 1'b0; bit_length = 8'd2; r2_mod = 8'd1;
        wait_done("midrun_start", 200);
        busy_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check("midrun_no_second_run", busy_seen, 0);

        // Asynchronous reset in the middle of a run.
        issue("reset_abort", 8'd7, 8'd5, 8'd13, 8'd4, 8'd9, 8'd11, 78);
        repeat (29) @(negedge clk);
        check("abort_busy_before_reset", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        issue("after_reset", 8'd7, 8'd5, 8'd13, 8'd4, 8'd9, 8'd11, 78);
        wait_done("after_reset", 200);

        // Random operands against an independent pow-mod model.
        for (int t = 0; t < 500; t++) begin
            rk = DW'($urandom_range(1, DW));
            rn = DW'(($urandom_range(0, (1 << (rk - 1)) - 1) << 1) | 1);
            rb = DW'($urandom % rn);
            re = DW'($urandom_range(0, 255));
            rr = DW'((1 << (2 * rk)) % rn);
            issue("random", rb, re, rn, rk, rr, powmod(rb, re, rn), exp_latency(rk, re));
            wait_done("random", 400);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
